// File: rtl/gray_scan_pkg.sv
// Shared constants for the Gray/binary scan counter: default rates, divider
// helper and the active-low hex-to-seven-segment table (bit 0 = a, bit 6 = g).
package gray_scan_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DIGITS   = 4;
  localparam int DEF_CLK_HZ   = 100_000_000;
  localparam int DEF_COUNT_HZ = 1;
  localparam int DEF_SCAN_HZ  = 1000;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Clocks per tick, never below one (one means a tick on every cycle).
  function automatic int tick_div(input int clk_hz, input int rate_hz);
    int d;
    d = clk_hz / rate_hz;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/gray_scan_counter_tick_gen.sv
// Free-running divider producing a one-cycle o_tick every DIV clocks.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst || o_tick) r_cnt <= '0;
    else                  r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/gray_scan_counter.sv
// Up/down counter with binary or Gray output, auto or synchronized manual
// stepping, wrap pulse and a multiplexed hex seven-segment display.
module gray_scan_counter
  import gray_scan_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DIGITS          = DEF_DIGITS,
  parameter int DEFAULT_FREQ_HZ = DEF_CLK_HZ,
  parameter int COUNT_FREQ_HZ   = DEF_COUNT_HZ,
  parameter int SCAN_FREQ_HZ    = DEF_SCAN_HZ
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_man_clk,
  input  logic              i_man_clk_en,
  input  logic              i_dir,
  input  logic              i_mode,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_wrap,
  output logic [6:0]        SEG_OUT,
  output logic [DIGITS-1:0] SEG_EN
);

  localparam int COUNT_DIV = tick_div(DEFAULT_FREQ_HZ, COUNT_FREQ_HZ);
  localparam int SCAN_DIV  = tick_div(DEFAULT_FREQ_HZ, SCAN_FREQ_HZ);
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic w_auto_tick;
  logic w_scan_tick;

  tick_gen #(.DIV(COUNT_DIV)) u_count_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_auto_tick)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_scan_tick)
  );

  logic r_man_meta, r_man_sync, r_man_prev;
  logic w_man_edge, w_step;

  // NOTE: the button is asynchronous; only r_man_sync (two flops deep) may feed logic.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_man_meta <= 1'b0;
      r_man_sync <= 1'b0;
      r_man_prev <= 1'b0;
    end else begin
      r_man_meta <= i_man_clk;
      r_man_sync <= r_man_meta;
      r_man_prev <= r_man_sync;
    end
  end

  assign w_man_edge = r_man_sync & ~r_man_prev;
  assign w_step     = i_man_clk_en ? w_man_edge : (w_auto_tick & i_en);

  logic [WIDTH-1:0] r_bin;
  logic             r_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_bin  <= '0;
      r_wrap <= 1'b0;
    end else if (i_load) begin
      r_bin  <= i_load_val;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_bin  <= i_dir ? r_bin + WIDTH'(1) : r_bin - WIDTH'(1);
      r_wrap <= i_dir ? (&r_bin) : ~(|r_bin);
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Mode only recodes the view; the binary state is untouched.
  assign o_count = i_mode ? (r_bin ^ (r_bin >> 1)) : r_bin;
  assign o_wrap  = r_wrap;

  logic [IDX_W-1:0]  r_scan_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [15:0]       w_count_ext;
  logic [15:0]       w_shifted;
  logic [3:0]        w_nibble;
  logic [6:0]        r_seg_out;
  logic [DIGITS-1:0] r_seg_en;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_idx_nxt = r_scan_idx;
    if (w_scan_tick)
      w_idx_nxt = (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + IDX_W'(1);
  end

  assign w_count_ext = 16'(o_count);
  assign w_shifted   = w_count_ext >> {w_idx_nxt, 2'b00};
  assign w_nibble    = w_shifted[3:0];

  // Enable and pattern are registered from the same index so they switch together.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_scan_idx <= '0;
      r_seg_en   <= ~DIGITS'(1);
      r_seg_out  <= SEG_LUT[0];
    end else begin
      r_scan_idx <= w_idx_nxt;
      r_seg_en   <= ~(DIGITS'(1) << w_idx_nxt);
      r_seg_out  <= SEG_LUT[w_nibble];
    end
  end

  assign SEG_OUT = r_seg_out;
  assign SEG_EN  = r_seg_en;

endmodule

// File: tb/tb_gray_scan_counter.sv
// Randomized and directed bench for gray_scan_counter: a 4-bit/3-digit and an
// 8-bit/4-digit instance share stimulus and are checked against a cycle model.
module tb_gray_scan_counter;

  localparam int CLK_HZ = 6;
  localparam int CNT_HZ = 3;
  localparam int SCN_HZ = 6;
  localparam int CDIV   = CLK_HZ / CNT_HZ;
  localparam int SDIV   = CLK_HZ / SCN_HZ;

  logic       clk = 1'b0;
  logic       rst, en, man_clk, man_en, dir, mode, load;
  logic [7:0] load_val;

  logic [3:0] cnt4;
  logic       wrap4;
  logic [6:0] seg4;
  logic [2:0] en4;
  logic [7:0] cnt8;
  logic       wrap8;
  logic [6:0] seg8;
  logic [3:0] en8;

  always #5 clk = ~clk;

  gray_scan_counter #(
    .WIDTH(4), .DIGITS(3), .DEFAULT_FREQ_HZ(CLK_HZ),
    .COUNT_FREQ_HZ(CNT_HZ), .SCAN_FREQ_HZ(SCN_HZ)
  ) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_man_clk(man_clk),
    .i_man_clk_en(man_en), .i_dir(dir), .i_mode(mode), .i_load(load),
    .i_load_val(load_val[3:0]), .o_count(cnt4), .o_wrap(wrap4),
    .SEG_OUT(seg4), .SEG_EN(en4)
  );

  gray_scan_counter #(
    .WIDTH(8), .DIGITS(4), .DEFAULT_FREQ_HZ(CLK_HZ),
    .COUNT_FREQ_HZ(CNT_HZ), .SCAN_FREQ_HZ(SCN_HZ)
  ) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_man_clk(man_clk),
    .i_man_clk_en(man_en), .i_dir(dir), .i_mode(mode), .i_load(load),
    .i_load_val(load_val), .o_count(cnt8), .o_wrap(wrap8),
    .SEG_OUT(seg8), .SEG_EN(en8)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counter value per instance, expected outputs after each edge.
  logic [6:0] hex7 [16];
  int  m_b      [2];
  int  m_idx    [2];
  int  m_seg_en [2];
  int  m_seg_out[2];
  bit  m_wrap   [2];
  int  n_edges;
  bit  man_hist [$];

  function automatic int wid(input int k); return (k == 0) ? 4 : 8; endfunction
  function automatic int dig(input int k); return (k == 0) ? 3 : 4; endfunction

  function automatic int code_of(input int k);
    int b;
    b = m_b[k];
    return mode ? (b ^ (b >> 1)) : b;
  endfunction

  task automatic model_edge();
    bit auto_t, scan_t, man_e, step;
    int mask;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_b[k] = 0; m_wrap[k] = 0; m_idx[k] = 0;
        m_seg_en[k]  = ((1 << dig(k)) - 1) & ~1;
        m_seg_out[k] = hex7[0];
      end
      n_edges  = 0;
      man_hist = '{0, 0, 0};
      return;
    end
    auto_t = (n_edges % CDIV) == CDIV - 1;
    scan_t = (n_edges % SDIV) == SDIV - 1;
    n_edges++;
    // A level first sampled at edge j yields a step at edge j+2.
    man_e = man_hist[man_hist.size() - 2] && !man_hist[man_hist.size() - 3];
    man_hist.push_back(man_clk);
    if (man_hist.size() > 4) void'(man_hist.pop_front());
    step = man_en ? man_e : (auto_t && en);
    for (int k = 0; k < 2; k++) begin
      mask = (1 << wid(k)) - 1;
      if (scan_t) m_idx[k] = (m_idx[k] + 1) % dig(k);
      m_seg_en[k]  = ((1 << dig(k)) - 1) & ~(1 << m_idx[k]);
      m_seg_out[k] = hex7[(code_of(k) >> (4 * m_idx[k])) & 15];
      if (load) begin
        m_b[k] = int'(load_val) & mask;
        m_wrap[k] = 0;
      end else if (step) begin
        m_wrap[k] = dir ? (m_b[k] == mask) : (m_b[k] == 0);
        m_b[k]    = (dir ? m_b[k] + 1 : m_b[k] - 1) & mask;
      end else begin
        m_wrap[k] = 0;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("cnt4",  cnt4,  code_of(0));
    check("wrap4", wrap4, m_wrap[0]);
    check("segen4", en4,  m_seg_en[0]);
    check("seg4",  seg4,  m_seg_out[0]);
    check("cnt8",  cnt8,  code_of(1));
    check("wrap8", wrap8, m_wrap[1]);
    check("segen8", en8,  m_seg_en[1]);
    check("seg8",  seg8,  m_seg_out[1]);
  endtask

  int gseq [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
  int prev, nchg, nwrap, base;
  logic [3:0] seen;

  initial begin
    hex7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b0; en = 1'b0; man_clk = 1'b0; man_en = 1'b0;
    dir = 1'b1; mode = 1'b0; load = 1'b0; load_val = '0;
    cycle(); cycle();
    check("rst_cnt8", cnt8, 0);
    check("rst_segen8", en8, 4'b1110);
    check("rst_seg8", seg8, 7'b1000000);

    // Gray walk over a full 4-bit period, one wrap at binary F->0.
    rst = 1'b1; mode = 1'b1; dir = 1'b1; en = 1'b1;
    prev = 0; nchg = 0; nwrap = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (wrap4) nwrap++;
      if (int'(cnt4) != prev) begin
        if (nchg < 16) check("gray_seq", cnt4, gseq[nchg]);
        nchg++;
        prev = int'(cnt4);
      end
    end
    check("gray_steps", nchg, 16);
    check("gray_wraps", nwrap, 1);

    // Down-step wrap from zero, then a load colliding with a step.
    en = 1'b0; mode = 1'b0; load = 1'b1; load_val = 8'h00;
    cycle();
    load = 1'b0; man_en = 1'b1; dir = 1'b0; man_clk = 1'b1;
    cycle(); cycle(); cycle();
    check("dn_wrap_cnt4", cnt4, 4'hF);
    check("dn_wrap_pulse4", wrap4, 1);
    check("dn_wrap_cnt8", cnt8, 8'hFF);
    cycle();
    check("dn_wrap_once", wrap4, 0);
    man_clk = 1'b0;
    cycle(); cycle(); cycle();
    load = 1'b1; load_val = 8'h00;
    cycle();
    load = 1'b0; man_clk = 1'b1;
    cycle(); cycle();
    load = 1'b1; load_val = 8'h05;
    cycle();
    check("load_over_step", cnt4, 4'h5);
    check("load_no_wrap", wrap4, 0);
    load = 1'b0; man_clk = 1'b0;
    cycle(); cycle(); cycle();

    // Ten-cycle button press with auto ticks running: one step, three edges late.
    dir = 1'b1; en = 1'b1; man_en = 1'b1;
    base = m_b[0];
    man_clk = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      check("man_once", cnt4, (i >= 3) ? ((base + 1) & 15) : base);
    end
    man_clk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("man_hold", cnt4, (base + 1) & 15);
    end

    // Scan of 0xA5 across four digits.
    man_en = 1'b0; en = 1'b0; load = 1'b1; load_val = 8'hA5;
    cycle();
    load = 1'b0;
    cycle();
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (en8 == 4'b1110 && seg8 == 7'b0010010) seen[0] = 1'b1;
      if (en8 == 4'b1101 && seg8 == 7'b0001000) seen[1] = 1'b1;
      if (en8 == 4'b1011 && seg8 == 7'b1000000) seen[2] = 1'b1;
      if (en8 == 4'b0111 && seg8 == 7'b1000000) seen[3] = 1'b1;
    end
    check("scan_digits", seen, 4'hF);

    // Reset with B=7 at scan index 2, during a load.
    load = 1'b1; load_val = 8'h07;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 4 && m_idx[1] != 2; i++) cycle();
    check("pre_rst_segen8", en8, 4'b1011);
    rst = 1'b0; load = 1'b1; load_val = 8'h33;
    cycle();
    check("mid_rst_cnt8", cnt8, 0);
    check("mid_rst_segen8", en8, 4'b1110);
    check("mid_rst_seg8", seg8, 7'b1000000);
    check("mid_rst_wrap8", wrap8, 0);
    rst = 1'b1; load = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 59) != 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 3) == 0)  man_clk = ~man_clk;
      if ($urandom_range(0, 39) == 0) man_en  = ~man_en;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) dir  = ~dir;
      if ($urandom_range(0, 9) == 0)  mode = ~mode;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
